// File: rtl/clarvi_avm_master_if.sv
// rtl/clarvi_avm_master_if.sv - Avalon-MM bus bundle between the clarvi master and the interconnect
interface clarvi_avm_master_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    waitrequest;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/clarvi_avm_master.sv
// rtl/clarvi_avm_master.sv - pipelined Avalon-MM master with read credits and an in-order response FIFO
module clarvi_avm_master #(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ORDER_WRITES    = 0,
    localparam int CW             = $clog2(MAX_OUTSTANDING) + 1,
    localparam int BW             = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [BW-1:0]         req_byteenable,
    input  logic [DATA_WIDTH-1:0] req_writedata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    clarvi_avm_master_if.master   avm,
    output logic [CW-1:0]         outstanding,
    output logic                  err_unexpected_rdv
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, CMD} state_t;

    state_t                state;
    logic                  cmd_write;
    logic                  rd_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BW-1:0]         be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  cmd_accept;
    logic                  cmd_read;
    logic                  slot_free;
    logic                  read_ok;
    logic                  write_ok;
    logic                  accept;
    logic [CW:0]           credit_sum;

    logic [DATA_WIDTH-1:0] mem [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         in_flight;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;

    assign avm.read       = rd_q;
    assign avm.write      = wr_q;
    assign avm.address    = addr_q;
    assign avm.byteenable = be_q;
    assign avm.writedata  = wdata_q;

    // A read parked in CMD becomes outstanding the moment the slave takes it,
    // so it always holds a credit, accepted this cycle or not.
    always_comb begin
        cmd_accept = (state == CMD) && !avm.waitrequest;
        cmd_read   = (state == CMD) && !cmd_write;
        slot_free  = (state == IDLE) || cmd_accept;
        credit_sum = {1'b0, outstanding} + {{CW{1'b0}}, cmd_read};
        read_ok    = credit_sum < (CW+1)'(MAX_OUTSTANDING);
        write_ok   = (ORDER_WRITES == 0) || ((outstanding == '0) && !cmd_read);
        req_ready  = slot_free && (req_write ? write_ok : read_ok);
        accept     = req_valid && req_ready;
        rd_issue   = cmd_accept && !cmd_write;
        pop        = resp_valid && resp_ready;
        in_flight  = outstanding - fifo_count;
        push       = avm.readdatavalid && (in_flight != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_write <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else if (accept) begin
            state     <= CMD;
            cmd_write <= req_write;
            rd_q      <= !req_write;
            wr_q      <= req_write;
            addr_q    <= req_address;
            be_q      <= req_byteenable;
            wdata_q   <= req_writedata;
        end else if (cmd_accept) begin
            state     <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_count         <= '0;
            err_unexpected_rdv <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (avm.readdatavalid && (in_flight == '0)) err_unexpected_rdv <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= avm.readdata;
    end

    assign resp_valid = (fifo_count != '0);
    assign resp_data  = mem[rd_ptr];

    fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (fifo_count == CW'(MAX_OUTSTANDING)) && !pop));
    credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
        outstanding <= CW'(MAX_OUTSTANDING));
    cmd_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        !(avm.read && avm.write));
endmodule

// File: tb/tb_clarvi_avm_master.sv
// tb/tb_clarvi_avm_master.sv - scoreboard bench for clarvi_avm_master
module tb_clarvi_avm_master;
    localparam int AW = 14, DW = 32, BW = 4, MAXO = 4, CW = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_address;
    logic [BW-1:0] req_byteenable;
    logic [DW-1:0] req_writedata;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic [CW-1:0] outstanding;
    logic          err;

    logic          b_req_valid, b_req_ready, b_req_write;
    logic [AW-1:0] b_req_address;
    logic [BW-1:0] b_req_byteenable;
    logic [DW-1:0] b_req_writedata;
    logic          b_resp_valid, b_resp_ready;
    logic [DW-1:0] b_resp_data;
    logic [CW-1:0] b_outstanding;
    logic          b_err;

    clarvi_avm_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    clarvi_avm_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    clarvi_avm_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .ORDER_WRITES(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_byteenable(req_byteenable), .req_writedata(req_writedata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .avm(bus), .outstanding(outstanding), .err_unexpected_rdv(err)
    );

    clarvi_avm_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .ORDER_WRITES(1)) dut_ordered (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_address(b_req_address), .req_byteenable(b_req_byteenable), .req_writedata(b_req_writedata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .avm(bus_b), .outstanding(b_outstanding), .err_unexpected_rdv(b_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return 32'hA0 + {18'b0, a};
    endfunction

    // Slave model: fixed-latency, in-order; waitrequest is driven by the stimulus.
    typedef struct { logic [DW-1:0] d; int due; } rsp_t;
    rsp_t rq[$];
    int   cyc = 0;
    int   lat = 1;
    logic force_rdv = 1'b0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!reset_n) rq.delete();
        else if (bus.read && !bus.waitrequest) rq.push_back('{rdata_of(bus.address), cyc + lat});
        #1;
        if (force_rdv) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = 32'h0000_0BAD;
        end else if (rq.size() > 0 && rq[0].due == cyc + 1) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = rq[0].d;
            void'(rq.pop_front());
        end else begin
            bus.readdatavalid = 1'b0;
        end
    end

    // Monitor and scoreboard
    logic [DW-1:0] exp_q[$];
    int   pops = 0, bus_reads = 0, stalls = 0, lat_err = 0, run = 0, run_max = 0, out_max = 0;
    int   bus_reads_at_pop[64];
    logic rdv_prev = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            rdv_prev = 1'b0;
        end else begin
            if (req_valid && req_ready && !req_write) exp_q.push_back(rdata_of(req_address));
            if (bus.read && !bus.waitrequest) bus_reads++;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) chk("rdata_extra", 1, 0);
                else chk("rdata", resp_data, exp_q.pop_front());
                bus_reads_at_pop[pops % 64] = bus_reads;
                pops++;
            end
            if (resp_valid != rdv_prev) lat_err++;
            rdv_prev = bus.readdatavalid;
            if (int'(outstanding) > out_max) out_max = int'(outstanding);
            if (bus.read) run++; else run = 0;
            if (run > run_max) run_max = run;
            if (req_valid && !req_ready && !req_write) stalls++;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        int   n = 0;
        logic acc = 1'b0;
        req_valid = 1'b1; req_write = w; req_address = a; req_writedata = d; req_byteenable = be;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = req_ready;
            n++;
            tick();
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != '0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int   bp, br, st, p0, viol;
        logic acc;
        req_valid = 0; req_write = 0; req_address = '0; req_byteenable = '0; req_writedata = '0;
        resp_ready = 1;
        bus.waitrequest = 0; bus.readdatavalid = 0; bus.readdata = '0;
        b_req_valid = 0; b_req_write = 0; b_req_address = '0; b_req_byteenable = 4'hF; b_req_writedata = '0;
        b_resp_ready = 0;
        bus_b.waitrequest = 0; bus_b.readdatavalid = 0; bus_b.readdata = '0;

        @(negedge clock);
        chk("rst_cmd", {bus.read, bus.write, bus.address, bus.byteenable, bus.writedata}, 0);
        chk("rst_resp", {resp_valid, outstanding, err}, 0);
        @(posedge clock); #1;
        reset_n = 1;

        // back-to-back reads on a zero-wait, latency-1 slave
        lat = 1;
        for (int i = 0; i < 8; i++) issue(1'b0, AW'(i), '0, 4'hF);
        req_valid = 0;
        wait_drain();
        chk("t1_read_run", run_max, 8);
        chk("t1_out_peak", out_max, 2);
        chk("t1_resp_latency", lat_err, 0);
        chk("t1_pops", pops, 8);

        // credit limit with a long-latency slave
        lat = 6; bp = pops; br = bus_reads; st = stalls;
        for (int i = 0; i < 6; i++) issue(1'b0, AW'(16 + i), '0, 4'hF);
        req_valid = 0;
        wait_drain();
        chk("t2_reads_before_first_pop", bus_reads_at_pop[bp % 64] - br, 4);
        chk("t2_req_ready_dropped", stalls > st, 1);
        chk("t2_out_max", out_max, 4);

        // write held by waitrequest, next read accepted on release
        lat = 1;
        bus.waitrequest = 1;
        issue(1'b1, 14'h12, 32'hDEADBEEF, 4'hF);
        req_valid = 1; req_write = 0; req_address = 14'd5;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.waitrequest = 0;
            @(negedge clock);
            chk("t3_hold", {bus.write, bus.read, bus.address, bus.writedata, bus.byteenable},
                {1'b1, 1'b0, 14'h12, 32'hDEADBEEF, 4'hF});
            chk("t3_ready", req_ready, (i == 3));
            tick();
        end
        req_valid = 0;
        @(negedge clock);
        chk("t3_next_read", {bus.read, bus.address}, {1'b1, 14'd5});
        tick();
        wait_drain();

        // posted write directly behind a read
        lat = 4;
        issue(1'b0, 14'h20, '0, 4'hF);
        req_valid = 1; req_write = 1; req_address = 14'h20; req_writedata = 32'h1234;
        @(negedge clock);
        chk("t4_read_on_bus", bus.read, 1);
        chk("t4_write_ready", req_ready, 1);
        tick();
        req_valid = 0;
        @(negedge clock);
        chk("t4_write_next", bus.write, 1);
        tick();
        wait_drain();

        // ordered write waits for the read response to be popped
        b_req_valid = 1; b_req_write = 0; b_req_address = 14'h20;
        @(negedge clock);
        chk("t4o_read_ready", b_req_ready, 1);
        tick();
        b_req_write = 1; b_req_writedata = 32'h5678;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            bus_b.readdatavalid = (i == 1);
            bus_b.readdata = 32'h55;
            @(negedge clock);
            if (bus_b.write || b_req_ready) viol++;
            tick();
        end
        chk("t4o_write_held", viol, 0);
        chk("t4o_resp", {b_resp_valid, b_resp_data}, {1'b1, 32'h55});
        b_resp_ready = 1;
        @(negedge clock);
        chk("t4o_ready_at_pop", b_req_ready, 0);
        tick();
        b_resp_ready = 0;
        @(negedge clock);
        chk("t4o_ready_after_pop", b_req_ready, 1);
        tick();
        b_req_valid = 0;
        @(negedge clock);
        chk("t4o_write_issued", bus_b.write, 1);
        tick();

        // full FIFO with backpressure, then drain
        lat = 2; resp_ready = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(8 + i), '0, 4'hF);
        req_valid = 1; req_write = 0; req_address = 14'd12;
        repeat (8) tick();
        @(negedge clock);
        chk("t5_valid", resp_valid, 1);
        chk("t5_first", resp_data, rdata_of(14'd8));
        chk("t5_ready_low", req_ready, 0);
        chk("t5_out", outstanding, 4);
        tick();
        resp_ready = 1; p0 = pops; acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (req_ready) acc = 1;
            tick();
            if (acc) req_valid = 0;
        end
        chk("t5_drain4", pops - p0, 4);
        while (!acc && p0 < 1000) begin
            @(negedge clock);
            if (req_ready) acc = 1;
            tick();
            p0 += 100;
        end
        req_valid = 0;
        wait_drain();

        // spurious readdatavalid
        @(negedge clock); force_rdv = 1;
        @(negedge clock); force_rdv = 0;
        @(negedge clock);
        chk("t6_err_set", err, 1);
        chk("t6_no_resp", resp_valid, 0);
        @(negedge clock);
        chk("t6_err_sticky", {err, resp_valid}, {1'b1, 1'b0});

        // asynchronous reset mid-burst
        tick();
        lat = 6;
        for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, 4'hF);
        req_valid = 0;
        tick();
        #2;
        reset_n = 0;
        #1;
        chk("t6_rst_bus", {bus.read, bus.write, bus.address}, 0);
        chk("t6_rst_core", {resp_valid, outstanding, err}, 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1;
        lat = 1; p0 = pops;
        issue(1'b0, 14'd3, '0, 4'hF);
        req_valid = 0;
        wait_drain();
        chk("t6_recover", pops - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
